gbd_block_buffer: RTL
=====================

Name: gbd_block_buffer

Overview:
- Double-banked byte buffer directly upstream of the SRAM bank0 writer; it is the source of that writer's BlockBufferDataReady, RequestReadBuffer, ReadBufferOffset, BufferDataReady and BufferReadResult signals.
- Accepts a camera pixel byte stream (valid/ready) and packs it into two ping-pong banks of BLOCK_BYTES each.
- Announces each completed bank to the writer, then serves random-access byte reads until the writer releases the bank.

Parameters:
BLOCK_AW, 8, log2 of bank size in bytes (BLOCK_BYTES = 1<<BLOCK_AW = 256)
BLKCNT_W, 16, width of completed-block counter

Ports:
sys_clock  in  1  system clock; all logic on posedge
sys_resetn  in  1  asynchronous active-low reset
NewRunReset  in  1  synchronous active-low local reset; same clearing as sys_resetn
in_valid  in  1  input byte valid
in_data  in  8  input byte; MSB = leftmost pixel
in_ready  out  1  buffer can accept in_data this cycle
BlockBufferDataReady  out  1  high while the read bank holds a complete block
BlockRelease  in  1  one-cycle pulse from writer: read bank consumed
RequestReadBuffer  in  1  one-cycle read request pulse
ReadBufferOffset  in  10  byte offset within read bank; bits [BLOCK_AW-1:0] used, upper bits ignored
BufferDataReady  out  1  one-cycle pulse: BufferReadResult valid
BufferReadResult  out  8  byte read
blocks_done  out  BLKCNT_W  count of banks filled since reset; wraps

Behaviour:
- Fixed decision: one clock (sys_clock); reset sys_resetn is asynchronous, active-low.
- Reset (sys_resetn low, or NewRunReset low at a clock edge) does all of the following:
  - bank_full[1:0]=0, write bank wb=0, read bank rb=0, write count wcnt=0.
  - in_ready=1 (first cycle after reset), BlockBufferDataReady=0, BufferDataReady=0, BufferReadResult=0, blocks_done=0.
  - Drops any pending read: no BufferDataReady is issued for a request in flight.
  - RAM contents are not cleared.
- Storage: 2*BLOCK_BYTES x 8 synchronous RAM, address {bank, offset}.
- Write side:
  - in_ready = !bank_full[wb], combinational from registered state.
  - A byte is accepted on a cycle with in_valid && in_ready: RAM[{wb,wcnt}] <= in_data, wcnt++.
  - When the accepted byte has wcnt == BLOCK_BYTES-1, on the same edge: bank_full[wb]<=1, wb toggles, wcnt<=0, blocks_done++ (wraps at 2^BLKCNT_W).
  - When both banks are full, in_ready=0; in_data is ignored and no state changes.
- Read-side announce:
  - BlockBufferDataReady is registered: next = bank_full[rb] && !release_cycle, where release_cycle is high for the cycle following an accepted release.
  - It therefore always drops for at least one cycle between blocks, giving the consumer a fresh rising edge.
  - Latency from the completing byte edge to BlockBufferDataReady high: 1 cycle when rb already points at that bank.
- Release:
  - BlockRelease while BlockBufferDataReady=1: bank_full[rb]<=0, rb toggles, BlockBufferDataReady<=0.
  - BlockRelease while BlockBufferDataReady=0: ignored.
- Simultaneous events:
  - Fill completion of bank wb and release of bank rb on the same edge both take effect.
  - If wb==rb at that edge (both banks were full): the released bank becomes writable and rb moves to the other, still-full bank. BlockBufferDataReady goes low for exactly one cycle, then high.
- Read port:
  - Two-state FSM: R_IDLE, R_PEND.
  - In R_IDLE, RequestReadBuffer=1 issues a RAM read at {rb, ReadBufferOffset[BLOCK_AW-1:0]} and moves to R_PEND.
  - R_PEND: RAM data registered to BufferReadResult, BufferDataReady pulses high for 1 cycle, return to R_IDLE.
  - Request at edge N gives BufferDataReady high during cycle N+2.
  - BufferReadResult holds its value until the next completed read.
  - RequestReadBuffer in R_PEND is ignored: one outstanding read at a time.
  - Reads while BlockBufferDataReady=0 are performed on bank rb and return stale RAM data; not an error.
  - Release during R_PEND: the read completes with data from the bank addressed at issue.
- Reads and writes use separate RAM ports and never conflict, since wb != rb whenever bank rb is being read and filled.

Test Plan:
- Reset, stream 256 bytes 0x00..0xFF with in_valid=1 -> BlockBufferDataReady rises 1 cycle after byte 0xFF accepted; blocks_done=1; in_ready stays 1.
- With block 0 ready, request offsets 0x000, 0x07F, 0x3FF (pulses spaced 3 cycles) -> BufferDataReady 2 cycles after each, BufferReadResult=0x00, 0x7F, 0xFF (offset 0x3FF wraps to 0xFF).
- Fill 512 bytes without releasing -> in_ready=0 after byte 511; byte 512 held off; BlockRelease -> in_ready=1 next cycle; BlockBufferDataReady low exactly 1 cycle, then high for bank 1.
- Two RequestReadBuffer pulses on consecutive cycles -> exactly one BufferDataReady pulse, with the first offset's data.
- BlockRelease while BlockBufferDataReady=0 -> no change to rb, bank_full or in_ready.
- NewRunReset low during R_PEND with bank 0 full -> no BufferDataReady, BlockBufferDataReady=0, blocks_done=0, in_ready=1.

Source files
------------

// File: rtl/gbd_block_buffer_if.sv
// Bundle of the byte-stream input, the writer-facing block handshake and the
// random-access read port of the block buffer. The buffer uses "slave" and the
// camera/writer side uses "master".
interface gbd_block_buffer_if #(
    parameter int BLKCNT_W = 16
);
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                BlockBufferDataReady;
    logic                BlockRelease;
    logic                RequestReadBuffer;
    logic [9:0]          ReadBufferOffset;
    logic                BufferDataReady;
    logic [7:0]          BufferReadResult;
    logic [BLKCNT_W-1:0] blocks_done;

    modport master (
        output in_valid, in_data, BlockRelease, RequestReadBuffer, ReadBufferOffset,
        input  in_ready, BlockBufferDataReady, BufferDataReady, BufferReadResult,
               blocks_done
    );

    modport slave (
        input  in_valid, in_data, BlockRelease, RequestReadBuffer, ReadBufferOffset,
        output in_ready, BlockBufferDataReady, BufferDataReady, BufferReadResult,
               blocks_done
    );
endinterface

// File: rtl/gbd_block_buffer.sv
// Ping-pong byte buffer in front of the SRAM bank0 writer. Incoming bytes fill
// bank wb; each completed bank is announced on BlockBufferDataReady and is
// served by a two-cycle random-access read port until the writer releases it.
module gbd_block_buffer #(
    parameter int BLOCK_AW = 8,
    parameter int BLKCNT_W = 16
) (
    input  logic              sys_clock,
    input  logic              sys_resetn,
    input  logic              NewRunReset,
    gbd_block_buffer_if.slave bus
);
    localparam int BLOCK_BYTES = 1 << BLOCK_AW;

    typedef enum logic {R_IDLE, R_PEND} rd_state_e;

    logic [1:0]          bank_full, bank_full_nxt;
    logic                wb, rb;
    logic [BLOCK_AW-1:0] wcnt;
    logic [BLKCNT_W-1:0] blocks_done_q;
    logic                bbdr_q;
    logic                accept, fill_done, release_acc;

    rd_state_e           rd_state, rd_state_nxt;
    logic                rd_issue, rd_complete;
    logic [7:0]          rd_data;
    logic [7:0]          result_q;
    logic                dr_q;

    logic [7:0]          mem [0:2*BLOCK_BYTES-1];

    // Offset bits above the bank size wrap within the bank and are dropped.
    logic unused_offset_bits;
    assign unused_offset_bits = ^bus.ReadBufferOffset[9:BLOCK_AW];

    assign bus.in_ready             = !bank_full[wb];
    assign bus.BlockBufferDataReady = bbdr_q;
    assign bus.BufferDataReady      = dr_q;
    assign bus.BufferReadResult     = result_q;
    assign bus.blocks_done          = blocks_done_q;

    assign accept      = bus.in_valid && !bank_full[wb];
    assign fill_done   = accept && (wcnt == {BLOCK_AW{1'b1}});
    assign release_acc = bus.BlockRelease && bbdr_q;

    // Bank occupancy after this edge: a release and a fill completion always
    // touch different banks, so both apply independently.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        bank_full_nxt = bank_full;
        if (release_acc) bank_full_nxt[rb] = 1'b0;
        if (fill_done)   bank_full_nxt[wb] = 1'b1;
    end

    // Write pointer, bank flags, read-bank pointer and block announce.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!sys_resetn) begin
            bank_full     <= '0;
            wb            <= 1'b0;
            rb            <= 1'b0;
            wcnt          <= '0;
            blocks_done_q <= '0;
            bbdr_q        <= 1'b0;
        end else if (!NewRunReset) begin
            bank_full     <= '0;
            wb            <= 1'b0;
            rb            <= 1'b0;
            wcnt          <= '0;
            blocks_done_q <= '0;
            bbdr_q        <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (accept) wcnt <= wcnt + BLOCK_AW'(1);
            if (fill_done) begin
                wb            <= ~wb;
                blocks_done_q <= blocks_done_q + BLKCNT_W'(1);
            end
            if (release_acc) rb <= ~rb;
            // Dropping for the release cycle guarantees a fresh rising edge per block.
            bbdr_q <= bank_full[rb] && !release_acc;
        end
    end

    // Read FSM state register.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn)       rd_state <= R_IDLE;
        else if (!NewRunReset) rd_state <= R_IDLE;
        else                   rd_state <= rd_state_nxt;
    end

    // Read FSM next state: one outstanding read, extra requests in R_PEND dropped.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_issue     = 1'b0;
        rd_complete  = 1'b0;
        case (rd_state)
            R_IDLE: if (bus.RequestReadBuffer) begin
                rd_issue     = 1'b1;
                rd_state_nxt = R_PEND;
            end
            R_PEND: begin
                rd_complete  = 1'b1;
                rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Dual-port byte RAM: write port on bank wb, registered read port on bank rb.
    always_ff @(posedge sys_clock) begin
        // NOTE: the RAM and its read register have no reset so they map onto block RAM; a run reset keeps contents.
        if (accept)   mem[{wb, wcnt}] <= bus.in_data;
        if (rd_issue) rd_data <= mem[{rb, bus.ReadBufferOffset[BLOCK_AW-1:0]}];
    end

    // Read result register and completion pulse; a local reset drops a pending read.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            result_q <= '0;
            dr_q     <= 1'b0;
        end else if (!NewRunReset) begin
            result_q <= '0;
            dr_q     <= 1'b0;
        end else begin
            dr_q <= rd_complete;
            if (rd_complete) result_q <= rd_data;
        end
    end
endmodule
